// File: rtl/inst_boot_loader.sv
// Instruction-memory port controller: muxes IF fetch with a byte-serial loader that packs bytes into words.
// Latency: each word is written the cycle after its 4th byte; load_done follows the last write by one cycle.
// Backpressure: none; every valid byte is taken in header/data states and dropped in RUN, FINISH and ERR.
module inst_boot_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] if_addr,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {RUN, HDR_HI, HDR_LO, DATA, FINISH, ERR} state_t;

  // Widened by one bit so a 16-bit length can be compared against DEPTH=65536 as well.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t        state;
  logic [15:0]   len;        // word count from the header
  logic [AW-1:0] word_idx;   // slot currently being filled / written
  logic [1:0]    byte_cnt;   // bytes already collected for the current word
  logic [23:0]   part;       // first three bytes of the word, oldest in the top byte
  logic [15:0]   hdr_len;
  logic          last_word;

  // The full length is only known in the cycle the low header byte arrives.
  assign hdr_len   = {len[15:8], rx_data};
  assign last_word = ({{(16-AW){1'b0}}, word_idx} == (len - 16'd1));

  // Memory address: CPU PC only while running, loader slot address in every other state.
  always_comb begin
    mem_addr = {{(30-AW){1'b0}}, word_idx, 2'b00};
    if (state == RUN) mem_addr = if_addr;
  end

  // Load-session FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      len       <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      part      <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        RUN: begin
          if (load_req) begin
            state    <= HDR_HI;
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        HDR_HI: begin
          if (rx_valid) begin
            len[15:8] <= rx_data;
            state     <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (rx_valid) begin
            len[7:0] <= rx_data;
            word_idx <= '0;
            byte_cnt <= '0;
            if (hdr_len == 16'd0) begin
              state     <= FINISH;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else if ({1'b0, hdr_len} > DEPTH_L) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // A write cycle retires the slot; the final one ends the session.
          if (mem_we) begin
            word_idx <= word_idx + AW'(1);
            if (last_word) begin
              state     <= FINISH;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end
          end
          // Bytes overlapping a write start the next word; none is expected after the last word.
          if (rx_valid && !(mem_we && last_word)) begin
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {part, rx_data};
              byte_cnt  <= '0;
            end else begin
              part     <= {part[15:0], rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        FINISH: begin
          state <= RUN;
        end
        ERR: begin
          if (load_req) begin
            state    <= HDR_HI;
            load_err <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Bench for inst_boot_loader: sessions described as byte lists, expected writes derived from
// big-endian packing of those bytes, actual writes gathered by a monitor and compared per session.
module tb_inst_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] if_addr;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int drv_cyc = 0;
  int done_cnt = 0;
  logic hold_at_done = 1'b1;
  logic hold_before_done = 1'b0;
  logic prev_hold = 1'b0;

  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];
  int          act_cyc[$];
  logic [7:0]  data_q[$];
  int          exp_cyc[$];

  inst_boot_loader #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .if_addr(if_addr), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every write and every load_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
      act_cyc.push_back(cyc);
    end
    if (load_done) begin
      done_cnt         <= done_cnt + 1;
      hold_at_done     <= cpu_hold;
      hold_before_done <= prev_hold;
    end
    prev_hold <= cpu_hold;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int pick(input int g);
    return (g >= 0) ? g : int'($urandom_range(2));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    rx_valid = 1'b0;
    load_req = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit req);
    repeat (gap) tick();
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    load_req = req;
    drv_cyc  = cyc;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1;
    rx_valid = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    data_q.push_back(w[31:24]);
    data_q.push_back(w[23:16]);
    data_q.push_back(w[15:8]);
    data_q.push_back(w[7:0]);
  endtask

  task automatic clear_mon();
    act_addr.delete();
    act_data.delete();
    act_cyc.delete();
    exp_cyc.delete();
  endtask

  task automatic run_check(input string name);
    logic [31:0] a;
    repeat (3) begin
      @(posedge clk); #1;
      a = $urandom;
      if_addr = a;
      #1;
      chk({name, ":run_addr"}, mem_addr, a);
      chk({name, ":run_we"}, {31'd0, mem_we}, 0);
      chk({name, ":run_hold"}, {31'd0, cpu_hold}, 0);
    end
  endtask

  // One load session whose data bytes are in data_q; len words go in the header.
  task automatic do_load(input int len, input int gap, input bit poke, input string name);
    int nw;
    int done0;
    logic [31:0] w;
    clear_mon();
    done0 = done_cnt;
    pulse_req();
    chk({name, ":hold_on"}, {31'd0, cpu_hold}, 1);
    chk({name, ":err_clr"}, {31'd0, load_err}, 0);
    send_byte(8'(len >> 8), pick(gap), 1'b0);
    send_byte(8'(len), pick(gap), 1'b0);
    for (int k = 0; k < data_q.size(); k++) begin
      send_byte(data_q[k], pick(gap), poke && ($urandom_range(3) == 0));
      if (k % 4 == 3) exp_cyc.push_back(drv_cyc + 1);
    end
    tick();
    for (int i = 0; i < 40 && done_cnt == done0; i++) @(posedge clk);
    chk({name, ":done_pulses"}, done_cnt - done0, 1);
    nw = data_q.size() / 4;
    chk({name, ":n_writes"}, act_addr.size(), nw);
    for (int i = 0; i < nw && i < act_addr.size(); i++) begin
      w = {data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]};
      chk($sformatf("%s:addr%0d", name, i), act_addr[i], i * 4);
      chk($sformatf("%s:data%0d", name, i), act_data[i], w);
      chk($sformatf("%s:wcyc%0d", name, i), act_cyc[i], exp_cyc[i]);
    end
    chk({name, ":hold_at_done"}, {31'd0, hold_at_done}, 0);
    chk({name, ":hold_before_done"}, {31'd0, hold_before_done}, 1);
    chk({name, ":err_after"}, {31'd0, load_err}, 0);
    run_check(name);
  endtask

  // Oversized header: the session must park in the error state with no writes.
  task automatic do_err(input logic [15:0] len, input string name);
    int done0;
    clear_mon();
    done0 = done_cnt;
    pulse_req();
    chk({name, ":hold_on"}, {31'd0, cpu_hold}, 1);
    send_byte(len[15:8], pick(-1), 1'b0);
    send_byte(len[7:0], pick(-1), 1'b0);
    repeat (6) send_byte(8'($urandom), pick(-1), 1'b0);
    tick();
    if_addr = 32'hFFFF_FFFF;
    #1;
    chk({name, ":err_flag"}, {31'd0, load_err}, 1);
    chk({name, ":err_hold"}, {31'd0, cpu_hold}, 1);
    chk({name, ":err_writes"}, act_addr.size(), 0);
    chk({name, ":err_done"}, done_cnt - done0, 0);
    chk({name, ":err_addr"}, mem_addr & 32'hFFFF_FC03, 0);
  endtask

  task automatic reset_mid_load();
    logic [31:0] a;
    clear_mon();
    pulse_req();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    tick();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_mid:hold", {31'd0, cpu_hold}, 0);
    chk("rst_mid:we", {31'd0, mem_we}, 0);
    chk("rst_mid:err", {31'd0, load_err}, 0);
    chk("rst_mid:done", {31'd0, load_done}, 0);
    a = $urandom;
    if_addr = a;
    #1;
    chk("rst_mid:addr", mem_addr, a);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid:writes", act_addr.size(), 0);
  endtask

  task automatic fill_random(input int len);
    data_q.delete();
    for (int k = 0; k < len * 4; k++) data_q.push_back(8'($urandom));
  endtask

  initial begin
    int len;
    reset    = 1'b0;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if_addr  = 32'h0000_0010;
    #12;
    chk("reset:addr", mem_addr, 32'h0000_0010);
    chk("reset:we", {31'd0, mem_we}, 0);
    chk("reset:hold", {31'd0, cpu_hold}, 0);
    chk("reset:done", {31'd0, load_done}, 0);
    chk("reset:err", {31'd0, load_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
    chk("idle:addr", mem_addr, 32'h0000_0010);

    data_q.delete();
    push_word(32'h2410_0000);
    push_word(32'h2411_0000);
    do_load(2, 0, 1'b0, "two_words");

    do_err(16'h0101, "hdr257");
    data_q.delete();
    do_load(0, 1, 1'b0, "empty");

    data_q.delete();
    push_word(32'h8E32_0000);
    do_load(1, 5, 1'b0, "gapped");

    reset_mid_load();
    fill_random(3);
    do_load(3, -1, 1'b0, "after_rst");

    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(1, 8);
      fill_random(len);
      do_load(len, -1, 1'b1, $sformatf("rand%0d", s));
    end

    do_err(16'($urandom_range(257, 65535)), "hdr_big");
    fill_random(2);
    do_load(2, -1, 1'b1, "retry");

    fill_random(256);
    do_load(256, 0, 1'b0, "full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
